// File: rtl/sev_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: one digit per scan slot,
// new values swapped in only at frame boundaries so a frame is never torn.
module sev_seg_scan_driver #(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV      = 100000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                      BrdClk,
    input  logic                      aReset_n,
    input  logic [4*NUM_DIGITS-1:0]   bValue,
    input  logic [NUM_DIGITS-1:0]     bDpMask,
    input  logic                      bLoad,
    input  logic                      bEnable,
    output logic [7:0]                bDigitSel,
    output logic [7:0]                bSegmentOutput,
    output logic                      bFrameDone
);

    localparam int              PRE_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_TC  = PRE_W'(SCAN_DIV - 1);
    localparam logic [2:0]      LAST_IDX = 3'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]          prescaler;
    logic [2:0]                digitIdx;
    logic [4*NUM_DIGITS-1:0]   shadowValue;
    logic [NUM_DIGITS-1:0]     shadowDp;
    logic                      pending;
    logic [4*NUM_DIGITS-1:0]   dispValue;
    logic [NUM_DIGITS-1:0]     dispDp;

    logic                      atTc;
    logic                      atBoundary;
    logic [3:0]                curNibble;
    logic                      curDp;
    logic                      curBlank;
    logic                      upperZero;
    logic [7:0]                segNext;
    logic [7:0]                selNext;

    assign atTc       = bEnable && (prescaler == PRE_TC);
    assign atBoundary = atTc && (digitIdx == LAST_IDX);

    function automatic logic [7:0] hexToSeg(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0: code = 8'h03;
            4'h1: code = 8'h9F;
            4'h2: code = 8'h25;
            4'h3: code = 8'h0D;
            4'h4: code = 8'h99;
            4'h5: code = 8'h49;
            4'h6: code = 8'h41;
            4'h7: code = 8'h1F;
            4'h8: code = 8'h01;
            4'h9: code = 8'h09;
            4'hA: code = 8'h11;
            4'hB: code = 8'hC1;
            4'hC: code = 8'h63;
            4'hD: code = 8'h85;
            4'hE: code = 8'h61;
            default: code = 8'h71;
        endcase
        return code;
    endfunction

    // Scan timing: the scan is parked on digit 0 whenever the display is disabled.
    always_ff @(posedge BrdClk) begin
        if (!aReset_n) begin
            prescaler <= '0;
            digitIdx  <= '0;
        end else if (!bEnable) begin
            prescaler <= '0;
            digitIdx  <= '0;
        end else if (atTc) begin
            prescaler <= '0;
            digitIdx  <= atBoundary ? 3'd0 : digitIdx + 3'd1;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    // A load coinciding with the wrap bypasses the shadow and lands directly.
    always_ff @(posedge BrdClk) begin
        if (!aReset_n) begin
            shadowValue <= '0;
            shadowDp    <= '0;
            pending     <= 1'b0;
            dispValue   <= '0;
            dispDp      <= '0;
        end else if (bLoad && atBoundary) begin
            dispValue <= bValue;
            dispDp    <= bDpMask;
            pending   <= 1'b0;
        end else if (bLoad) begin
            shadowValue <= bValue;
            shadowDp    <= bDpMask;
            pending     <= 1'b1;
        end else if (atBoundary && pending) begin
            dispValue <= shadowValue;
            dispDp    <= shadowDp;
            pending   <= 1'b0;
        end
    end

    always_comb begin
        curNibble = 4'h0;
        curDp     = 1'b0;
        curBlank  = 1'b0;
        upperZero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upperZero = upperZero && (dispValue[4*i +: 4] == 4'h0);
            if (digitIdx == 3'(i)) begin
                curNibble = dispValue[4*i +: 4];
                curDp     = dispDp[i];
                curBlank  = (BLANK_LEADING != 0) && (i != 0) && upperZero;
            end
        end
    end

    always_comb begin
        segNext    = curBlank ? 8'hFF : hexToSeg(curNibble);
        segNext[0] = ~curDp;
        selNext    = ~(8'h01 << digitIdx);
    end

    always_ff @(posedge BrdClk) begin
        if (!aReset_n || !bEnable) begin
            bDigitSel      <= 8'hFF;
            bSegmentOutput <= 8'hFF;
            bFrameDone     <= 1'b0;
        end else begin
            bDigitSel      <= selNext;
            bSegmentOutput <= segNext;
            bFrameDone     <= atBoundary;
        end
    end

endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// Scoreboard bench: stimulus queues expected per-slot codes, a monitor pops one
// entry each time a new digit slot appears on the anode lines.
module tb_sev_seg_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;

    logic        BrdClk = 1'b0;
    logic        aReset_n;
    logic [15:0] bValue;
    logic [3:0]  bDpMask;
    logic        bLoad;
    logic        bEnable;
    logic [7:0]  sel, seg, sel2, seg2;
    logic        fd, fd2;

    always #5 BrdClk = ~BrdClk;

    sev_seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_LEADING(1)) dutBlank (
        .BrdClk(BrdClk), .aReset_n(aReset_n), .bValue(bValue), .bDpMask(bDpMask),
        .bLoad(bLoad), .bEnable(bEnable), .bDigitSel(sel), .bSegmentOutput(seg),
        .bFrameDone(fd));

    sev_seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_LEADING(0)) dutNoBlank (
        .BrdClk(BrdClk), .aReset_n(aReset_n), .bValue(bValue), .bDpMask(bDpMask),
        .bLoad(bLoad), .bEnable(bEnable), .bDigitSel(sel2), .bSegmentOutput(seg2),
        .bFrameDone(fd2));

    typedef struct {
        logic [7:0] sel;
        logic [7:0] seg;
        logic [7:0] segNb;
    } slotExp_t;

    slotExp_t   expQ[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] prevSel = 8'hFF;
    slotExp_t   monItem;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushFrame(input logic [7:0] s0, s1, s2, s3, n0, n1, n2, n3);
        expQ.push_back('{8'hFE, s0, n0});
        expQ.push_back('{8'hFD, s1, n1});
        expQ.push_back('{8'hFB, s2, n2});
        expQ.push_back('{8'hF7, s3, n3});
    endtask

    task automatic loadVal(input logic [15:0] v, input logic [3:0] dp);
        bValue  = v;
        bDpMask = dp;
        bLoad   = 1'b1;
        @(negedge BrdClk);
        bLoad   = 1'b0;
    endtask

    task automatic advance(input int n);
        repeat (n) @(negedge BrdClk);
    endtask

    task automatic waitFrameDone(input string name);
        int n;
        n = 0;
        do begin
            @(negedge BrdClk);
            n++;
        end while (fd !== 1'b1 && n < 100);
        if (fd !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: no frame done within %0d cycles", name, n);
        end
    endtask

    // Monitor: a new non-dark anode pattern marks the start of a slot.
    initial begin
        forever begin
            @(negedge BrdClk);
            if (!$isunknown(sel) && sel !== prevSel && sel !== 8'hFF && expQ.size() > 0) begin
                monItem = expQ.pop_front();
                checkVal("slot sel", 32'(sel), 32'(monItem.sel));
                checkVal("slot seg", 32'(seg), 32'(monItem.seg));
                checkVal("slot sel noblank", 32'(sel2), 32'(monItem.sel));
                checkVal("slot seg noblank", 32'(seg2), 32'(monItem.segNb));
            end
            prevSel = sel;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        int hi;
        aReset_n = 1'b0;
        bEnable  = 1'b1;
        bValue   = '0;
        bDpMask  = '0;
        bLoad    = 1'b0;

        repeat (3) @(posedge BrdClk);
        @(negedge BrdClk);
        checkVal("reset sel", 32'(sel), 32'hFF);
        checkVal("reset seg", 32'(seg), 32'hFF);
        checkVal("reset fd", 32'(fd), 32'h0);
        checkVal("reset fd noblank", 32'(fd2), 32'h0);

        pushFrame(8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h03, 8'h03, 8'h03);
        aReset_n = 1'b1;
        @(negedge BrdClk);
        checkVal("first slot sel", 32'(sel), 32'hFE);
        waitFrameDone("first frame");

        @(negedge BrdClk);
        n = 1;
        checkVal("fd pulse width", 32'(fd), 32'h0);
        while (fd !== 1'b1 && n < 100) begin
            @(negedge BrdClk);
            n++;
        end
        checkVal("frame period", 32'(n), 32'(ND * SD));

        // Blanking: 00A5 shows only after the next boundary.
        pushFrame(8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h03, 8'h03, 8'h03);
        pushFrame(8'h49, 8'h11, 8'hFF, 8'hFF, 8'h49, 8'h11, 8'h03, 8'h03);
        loadVal(16'h00A5, 4'b0000);
        waitFrameDone("blank frame 1");
        waitFrameDone("blank frame 2");

        // Mid-frame load keeps the running frame intact.
        pushFrame(8'h49, 8'h11, 8'hFF, 8'hFF, 8'h49, 8'h11, 8'h03, 8'h03);
        pushFrame(8'h99, 8'h0D, 8'h25, 8'h9F, 8'h99, 8'h0D, 8'h25, 8'h9F);
        advance(6);
        loadVal(16'h1234, 4'b0000);
        waitFrameDone("tear frame");

        // Two loads in one frame: last one wins.
        pushFrame(8'h63, 8'h03, 8'hC1, 8'hFF, 8'h63, 8'h03, 8'hC1, 8'h03);
        advance(2);
        loadVal(16'h5555, 4'b0000);
        advance(5);
        loadVal(16'h0B0C, 4'b0000);
        waitFrameDone("double load 1");
        waitFrameDone("double load 2");

        // Load coinciding with the wrap goes straight to the display.
        pushFrame(8'h63, 8'h03, 8'hC1, 8'hFF, 8'h63, 8'h03, 8'hC1, 8'h03);
        pushFrame(8'h71, 8'h71, 8'h71, 8'h71, 8'h71, 8'h71, 8'h71, 8'h71);
        advance(15);
        loadVal(16'hFFFF, 4'b0000);
        checkVal("collision fd", 32'(fd), 32'h1);
        waitFrameDone("collision frame");

        // Zero value with decimal points on digits 0 and 2.
        pushFrame(8'h71, 8'h71, 8'h71, 8'h71, 8'h71, 8'h71, 8'h71, 8'h71);
        pushFrame(8'h02, 8'hFF, 8'hFE, 8'hFF, 8'h02, 8'h03, 8'h02, 8'h03);
        loadVal(16'h0000, 4'b0101);
        waitFrameDone("dp frame 1");
        waitFrameDone("dp frame 2");

        // Disable mid-slot, load while dark, re-enable.
        advance(5);
        bEnable = 1'b0;
        @(negedge BrdClk);
        checkVal("disable sel", 32'(sel), 32'hFF);
        checkVal("disable seg", 32'(seg), 32'hFF);
        checkVal("disable seg noblank", 32'(seg2), 32'hFF);
        loadVal(16'h0007, 4'b0000);
        hi = 0;
        repeat (8) begin
            @(negedge BrdClk);
            if (fd === 1'b1) hi++;
        end
        checkVal("disable fd quiet", 32'(hi), 32'h0);
        checkVal("disable sel held", 32'(sel), 32'hFF);
        pushFrame(8'h02, 8'hFF, 8'hFE, 8'hFF, 8'h02, 8'h03, 8'h02, 8'h03);
        pushFrame(8'h1F, 8'hFF, 8'hFF, 8'hFF, 8'h1F, 8'h03, 8'h03, 8'h03);
        bEnable = 1'b1;
        @(negedge BrdClk);
        checkVal("reenable sel", 32'(sel), 32'hFE);
        waitFrameDone("reenable frame 1");
        waitFrameDone("reenable frame 2");

        // Reset mid-frame with a pending load: everything discarded.
        advance(3);
        loadVal(16'h8888, 4'b1111);
        advance(2);
        aReset_n = 1'b0;
        repeat (2) @(negedge BrdClk);
        checkVal("midreset sel", 32'(sel), 32'hFF);
        checkVal("midreset seg", 32'(seg), 32'hFF);
        checkVal("midreset fd", 32'(fd), 32'h0);
        pushFrame(8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h03, 8'h03, 8'h03);
        pushFrame(8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h03, 8'h03, 8'h03);
        aReset_n = 1'b1;
        waitFrameDone("post reset 1");
        waitFrameDone("post reset 2");

        advance(2);
        checkVal("queue drained", 32'(expQ.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
